sp_divmod: RTL and testbench
============================

# sp_divmod

Parametrised multi-cycle integer divider returning quotient and remainder, selectable signed/unsigned, with explicit divide-by-zero reporting. Successor to the fixed-function `sp_divS` and `sp_divU` cores in the ScalaPipe arithmetic library. It keeps their `(clk, rst, operands, result, ready)` start/complete convention so generated kernels and benches drive it identically. It adds a remainder output, a compile-time signedness mode, and fixed, documented results for the corner cases.

## Interface
- `WIDTH`, 32: operand/result width in bits; legal range 2..64.
- `SIGNED`, 1: 1 = two's-complement truncating division; 0 = unsigned.
- `clk`  in  1  rising-edge clock; the block uses this one clock only.
- `rst`  in  1  synchronous, active-high reset; doubles as start (operands are captured while high).
- `a`  in  WIDTH  dividend.
- `b`  in  WIDTH  divisor.
- `quotient`  out  WIDTH  a / b.
- `remainder`  out  WIDTH  a % b.
- `ready`  out  1  results valid; held until next `rst`.
- `div_zero`  out  1  b was zero; qualified by `ready`.

## Operation
- States: LOAD, ITER, FIX, DONE.
- LOAD (any edge with `rst`=1):
  - Capture `a` and `b`.
  - Compute magnitudes: `|x|` when SIGNED, else raw.
  - Record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Clear the iteration counter.
  - Drive `ready`, `quotient`, `remainder` and `div_zero` to 0.
  - Next state is ITER.
- ITER: one restoring radix-2 step per cycle, MSB of the dividend first.
  - Partial remainder is WIDTH+1 bits.
  - Step: shift in the next dividend bit, trial-subtract the divisor magnitude, keep the result if non-negative, shift the quotient bit in.
  - The counter runs 0..WIDTH-1; leave for FIX after the step with count WIDTH-1.
- FIX: apply the sign corrections, register the outputs, and set `ready`. Next state is DONE.
- DONE: outputs and `ready` are held stable; no further activity until `rst`.
- Width rules:
  - The magnitude of the most negative value (2^(WIDTH-1)) is representable as an unsigned WIDTH-bit number; no extra bit is needed.
  - Quotient is negated iff the quotient sign is 1. Remainder is negated iff the dividend was negative. This is truncation toward zero, matching Verilog `/` and `%` on signed operands.
- Boundary cases:
  - b = 0: `quotient` = all ones; `remainder` = a (unchanged); `div_zero` = 1. Latency is unchanged (fixed-latency block).
  - SIGNED and a = 2^(WIDTH-1) and b = -1: `quotient` = a (wraps); `remainder` = 0; `div_zero` = 0.
  - a = 0: `quotient` = 0, `remainder` = 0.
  - |a| < |b|: `quotient` = 0, `remainder` = a.
  - `rst` asserted in ITER, FIX or DONE: abort, reload operands, clear outputs on that edge; no partial result is ever flagged.
  - `a` and `b` changing after `rst` falls: no effect on the operation in flight.

## Timing
- Edge 0 is defined as the first rising edge at which `rst` is sampled 0.
- Edges 0..WIDTH-1: ITER steps.
- Edge WIDTH: FIX; outputs and `ready`=1 become visible after this edge.
- Total latency: WIDTH+1 cycles from `rst` falling to `ready`, for all operand values including the corner cases.
- A bench loop that pulses `rst` for one cycle and then clocks while `!ready` sees `ready` after exactly WIDTH+1 low clocks.
- Reset values, valid after any edge with `rst`=1: `ready`=0, `quotient`=0, `remainder`=0, `div_zero`=0.
- There is no backpressure. Results persist indefinitely in DONE.

## Structure
- State encodings (LOAD/ITER/FIX/DONE, 2 bits) go in `scalapipe.v` alongside the existing core constants, not in local defines.
- Counter width comes from a `clog2`-style helper in the same include.
- One sub-module, `sp_divstep`: combinational single restoring step.
  - Inputs: partial remainder (WIDTH+1), divisor magnitude (WIDTH), incoming dividend bit.
  - Outputs: next partial remainder, quotient bit.
  - Keeps the step replaceable by a radix-4 version later.
- Top level holds the state register, counter, sign flags and output registers.

## Test plan
- WIDTH=32, SIGNED=1: a=-1234124124, b=134123 -> `quotient`=-9201, `remainder`=-58401, `div_zero`=0; `ready` exactly 33 cycles after `rst` falls.
- WIDTH=32, SIGNED=0: a=100, b=7 -> `quotient`=14, `remainder`=2. Then a=0xFFFFFFFF, b=2 -> `quotient`=0x7FFFFFFF, `remainder`=1.
- WIDTH=32, SIGNED=1: a=5, b=0 -> `quotient`=0xFFFFFFFF, `remainder`=5, `div_zero`=1, latency 33. Then a=0x80000000, b=0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0, `div_zero`=0.
- Reset mid-operation, WIDTH=32, SIGNED=1: start 1000/3; assert `rst` after 10 ITER cycles with a=7, b=-2 -> `ready` stays 0 throughout; final `quotient`=-3, `remainder`=1, 33 cycles after the second `rst` falls.
- WIDTH=8, SIGNED=1: a=-128, b=7 -> `quotient`=-18, `remainder`=-2; latency 9.
- Randomized follow-on: 1000 seeded operand pairs per (WIDTH in {8,32}, SIGNED in {0,1}) -> results match Verilog `/` and `%`, except b=0 which matches the rule above; latency constant.

Source files
------------

// File: rtl/sp_divmod_pkg.sv
// Shared types and helpers for the sp_divmod divider: state encoding,
// captured sign/zero flags and a width helper for the iteration counter.
package sp_divmod_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Everything the FIX step needs to know about the original operands.
    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic b_zero;
    } div_flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sp_divstep.sv
// One restoring radix-2 division step: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it does not go negative.
module sp_divstep
    import sp_divmod_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   pr_in,
    input  logic [WIDTH-1:0] dvs,
    input  logic             bit_in,
    output logic [WIDTH:0]   pr_out,
    output logic             q_bit
);

    // One extra bit beyond the shifted remainder carries the borrow.
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial  = {pr_in, bit_in} - {2'b00, dvs};
        q_bit  = ~trial[WIDTH+1];
        pr_out = q_bit ? trial[WIDTH:0] : {pr_in[WIDTH-1:0], bit_in};
    end

endmodule

// File: rtl/sp_divmod.sv
// Fixed-latency multi-cycle divider producing quotient and remainder; rst
// doubles as start and the result appears WIDTH+1 cycles after it falls.
module sp_divmod
    import sp_divmod_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             div_zero
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   pr_q, pr_nxt;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic             q_bit;
    div_flags_t       flags_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             out_load;

    // 2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_neg = SIGNED && a[WIDTH-1];
        b_neg = SIGNED && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    sp_divstep #(.WIDTH(WIDTH)) u_step (
        .pr_in  (pr_q),
        .dvs    (dvs_q),
        .bit_in (dvd_q[WIDTH-1]),
        .pr_out (pr_nxt),
        .q_bit  (q_bit)
    );

    // Every rst edge is the LOAD step, so the register always leaves it in ITER.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_ITER;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: state_d = ST_ITER;
            ST_ITER: if (cnt_q == LAST) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_ITER;
        endcase
    end

    // Dividend register shifts out its MSB each step and fills with quotient bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q          <= a_mag;
            dvs_q          <= b_mag;
            pr_q           <= '0;
            cnt_q          <= '0;
            flags_q.q_neg  <= a_neg ^ b_neg;
            flags_q.r_neg  <= a_neg;
            flags_q.b_zero <= (b == '0);
        end else if (state_q == ST_ITER) begin
            pr_q  <= pr_nxt;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // With a zero divisor every step subtracts nothing, leaving |a| in the
    // remainder; the normal sign fix then restores a exactly.
    always_comb begin
        out_load = (state_q == ST_FIX);
        q_fix    = flags_q.q_neg ? -dvd_q : dvd_q;
        if (flags_q.b_zero) q_fix = '1;
        r_fix    = flags_q.r_neg ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ready     <= 1'b0;
        end else if (out_load) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= flags_q.b_zero;
            ready     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_divmod.sv
// Four divider configurations run in lockstep from one rst; results are
// scoreboarded against an integer-arithmetic reference model.
module tb_sp_divmod;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a32s, b32s, a32u, b32u, q32s, r32s, q32u, r32u;
    logic [7:0]  a8s, b8s, a8u, b8u, q8s, r8s, q8u, r8u;
    logic        rdy32s, rdy32u, rdy8s, rdy8u, dz32s, dz32u, dz8s, dz8u;

    sp_divmod #(.WIDTH(32), .SIGNED(1'b1)) u32s (
        .clk(clk), .rst(rst), .a(a32s), .b(b32s),
        .quotient(q32s), .remainder(r32s), .ready(rdy32s), .div_zero(dz32s));
    sp_divmod #(.WIDTH(32), .SIGNED(1'b0)) u32u (
        .clk(clk), .rst(rst), .a(a32u), .b(b32u),
        .quotient(q32u), .remainder(r32u), .ready(rdy32u), .div_zero(dz32u));
    sp_divmod #(.WIDTH(8), .SIGNED(1'b1)) u8s (
        .clk(clk), .rst(rst), .a(a8s), .b(b8s),
        .quotient(q8s), .remainder(r8s), .ready(rdy8s), .div_zero(dz8s));
    sp_divmod #(.WIDTH(8), .SIGNED(1'b0)) u8u (
        .clk(clk), .rst(rst), .a(a8u), .b(b8u),
        .quotient(q8u), .remainder(r8u), .ready(rdy8u), .div_zero(dz8u));

    logic [31:0] gq [4];
    logic [31:0] gr [4];
    logic        grdy [4];
    logic        gdz [4];
    assign gq[0] = q32s;           assign gr[0] = r32s;
    assign gq[1] = q32u;           assign gr[1] = r32u;
    assign gq[2] = {24'd0, q8s};   assign gr[2] = {24'd0, r8s};
    assign gq[3] = {24'd0, q8u};   assign gr[3] = {24'd0, r8u};
    assign grdy[0] = rdy32s; assign grdy[1] = rdy32u; assign grdy[2] = rdy8s; assign grdy[3] = rdy8u;
    assign gdz[0]  = dz32s;  assign gdz[1]  = dz32u;  assign gdz[2]  = dz8s;  assign gdz[3]  = dz8u;

    int   total = 0;
    int   bad = 0;
    int   lowcnt = 0;
    logic rst_q = 1'b0;
    bit   done [4];
    exp_t sb0[$], sb1[$], sb2[$], sb3[$];
    logic [31:0] na [4];
    logic [31:0] nb [4];

    function automatic int wd(input int i);
        return (i < 2) ? 32 : 8;
    endfunction

    function automatic bit sg(input int i);
        return (i % 2) == 0;
    endfunction

    function automatic string nm(input int i);
        case (i)
            0: return "w32_signed";
            1: return "w32_unsigned";
            2: return "w8_signed";
            default: return "w8_unsigned";
        endcase
    endfunction

    // Reference: plain integer division on the width-truncated operand values.
    function automatic exp_t model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint m, ua, ub, sa, sb, qq, rr;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (s && ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (s && ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        if (sb == 0) begin
            e.q  = 32'(m);
            e.r  = 32'(ua);
            e.dz = 1'b1;
        end else begin
            qq   = sa / sb;
            rr   = sa % sb;
            e.q  = 32'(qq & m);
            e.r  = 32'(rr & m);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_a(input int i);
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'h1 << (wd(i) - 1);
            2: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd_b(input int i);
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'($urandom_range(1, 15));
            2: return 32'd0 - 32'($urandom_range(1, 15));
            3: return 32'hFFFF_FFFF;
            4: return (wd(i) == 8) ? 32'($urandom_range(1, 255)) : 32'($urandom);
            default: return 32'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        rst_q  <= rst;
        lowcnt <= rst ? 0 : lowcnt + 1;
    end

    // Monitor: checks reset clearing and pops one expectation per ready rise.
    always @(negedge clk) begin
        exp_t e;
        int   n;
        for (int i = 0; i < 4; i++) begin
            if (rst_q) begin
                total++;
                if (grdy[i] || gdz[i] || gq[i] != 32'd0 || gr[i] != 32'd0) begin
                    bad++;
                    $display("FAIL reset_clear %s: ready=%0b div_zero=%0b q=%h r=%h, required all zero",
                             nm(i), grdy[i], gdz[i], gq[i], gr[i]);
                end
                done[i] = 1'b0;
            end else if (grdy[i] && !done[i]) begin
                done[i] = 1'b1;
                n = 0;
                e = '0;
                case (i)
                    0: begin n = sb0.size(); if (n > 0) e = sb0.pop_front(); end
                    1: begin n = sb1.size(); if (n > 0) e = sb1.pop_front(); end
                    2: begin n = sb2.size(); if (n > 0) e = sb2.pop_front(); end
                    default: begin n = sb3.size(); if (n > 0) e = sb3.pop_front(); end
                endcase
                total++;
                if (n == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready %s: ready=1 after %0d low cycles with no result pending",
                             nm(i), lowcnt);
                end else begin
                    if (gq[i] !== e.q || gr[i] !== e.r || gdz[i] !== e.dz) begin
                        bad++;
                        $display("FAIL result %s: got q=%h r=%h dz=%0b, expected q=%h r=%h dz=%0b",
                                 nm(i), gq[i], gr[i], gdz[i], e.q, e.r, e.dz);
                    end
                    total++;
                    if (lowcnt != wd(i) + 1) begin
                        bad++;
                        $display("FAIL latency %s: got %0d cycles, expected %0d", nm(i), lowcnt, wd(i) + 1);
                    end
                end
            end else if (done[i] && !grdy[i]) begin
                total++;
                bad++;
                $display("FAIL ready_held %s: ready=0 before next rst, expected 1", nm(i));
                done[i] = 1'b0;
            end
        end
    end

    task automatic rand_all();
        for (int i = 0; i < 4; i++) begin
            na[i] = rnd_a(i);
            nb[i] = rnd_b(i);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] y);
        na[i] = x;
        nb[i] = y;
    endtask

    // One-cycle rst pulse with na/nb; operands are scrambled once rst falls.
    task automatic launch(input bit [3:0] mask);
        @(negedge clk);
        a32s = na[0]; b32s = nb[0];
        a32u = na[1]; b32u = nb[1];
        a8s  = na[2][7:0]; b8s = nb[2][7:0];
        a8u  = na[3][7:0]; b8u = nb[3][7:0];
        rst  = 1'b1;
        if (mask[0]) sb0.push_back(model(wd(0), sg(0), na[0], nb[0]));
        if (mask[1]) sb1.push_back(model(wd(1), sg(1), na[1], nb[1]));
        if (mask[2]) sb2.push_back(model(wd(2), sg(2), na[2], nb[2]));
        if (mask[3]) sb3.push_back(model(wd(3), sg(3), na[3], nb[3]));
        @(negedge clk);
        rst  = 1'b0;
        a32s = $urandom; b32s = $urandom; a32u = $urandom; b32u = $urandom;
        a8s  = 8'($urandom); b8s = 8'($urandom); a8u = 8'($urandom); b8u = 8'($urandom);
    endtask

    task automatic wait_all(input bit [3:0] mask);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            ok = 1'b1;
            for (int i = 0; i < 4; i++)
                if (mask[i] && !done[i]) ok = 1'b0;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: ready mask not complete after %0d cycles, required %b", n, mask);
        end
    endtask

    initial begin
        a32s = '0; b32s = '0; a32u = '0; b32u = '0;
        a8s  = '0; b8s  = '0; a8u  = '0; b8u  = '0;
        for (int i = 0; i < 4; i++) begin
            na[i]   = '0;
            nb[i]   = 32'd1;
            done[i] = 1'b0;
        end
        repeat (3) @(posedge clk);

        rand_all();
        set_ops(0, -1234124124, 134123);
        set_ops(1, 100, 7);
        set_ops(2, 32'hFFFF_FF80, 7);
        launch(4'hF);
        wait_all(4'hF);

        rand_all();
        set_ops(0, 5, 0);
        set_ops(1, 32'hFFFF_FFFF, 2);
        set_ops(2, 32'h80, 32'hFF);
        set_ops(3, 200, 0);
        launch(4'hF);
        wait_all(4'hF);

        rand_all();
        set_ops(0, 32'h8000_0000, 32'hFFFF_FFFF);
        set_ops(1, 0, 5);
        set_ops(2, 3, -7);
        set_ops(3, 255, 255);
        launch(4'hF);
        wait_all(4'hF);

        // Abort: the 32-bit units restart mid-ITER and must never flag 1000/3.
        rand_all();
        set_ops(0, 1000, 3);
        launch(4'b1100);
        wait_all(4'b1100);
        rand_all();
        set_ops(0, 7, -2);
        launch(4'hF);
        wait_all(4'hF);

        repeat (1000) begin
            rand_all();
            launch(4'hF);
            wait_all(4'hF);
        end

        repeat (3) @(posedge clk);
        total++;
        if (sb0.size() + sb1.size() + sb2.size() + sb3.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results never produced, expected 0",
                     sb0.size() + sb1.size() + sb2.size() + sb3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
